// File: rtl/gate_test_pkg.sv
// Shared types and constants for the gate test stages: FSM states,
// 2-input truth tables and the result-counter width helper.
package gate_test_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Bit v of each table is the expected gate output for input vector v.
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_XOR  = 4'b0110;

  // A full sweep can mismatch on all 2**n_in vectors, which needs n_in+1 bits.
  function automatic int count_width(input int n_in);
    return n_in + 1;
  endfunction

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter with a zero flag; holds at zero until reloaded.
module settle_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/gate_truth_sequencer.sv
// Drives every input vector of a gate under test in ascending order, lets it
// settle, samples the gate output and compares it against a truth table.
//
// Handshake: start is a level sampled on each rising edge; it is accepted only
// in IDLE or DONE and ignored while busy. There is no backpressure on in_vec.
module gate_truth_sequencer
  import gate_test_pkg::*;
#(
  parameter int                   N_IN   = 2,
  parameter int                   SETTLE = 1,
  parameter logic [(2**N_IN)-1:0] TRUTH  = TT_OR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [N_IN-1:0] in_vec,
  input  logic            dut_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] fail_vec,
  output logic            fail_valid,
  output state_t          fsm_state
);

  localparam int              CW       = count_width(N_IN);
  localparam int              TW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [TW-1:0]   RELOAD   = TW'(SETTLE - 1);
  localparam logic [N_IN-1:0] LAST_VEC = '1;

  if (SETTLE < 1 || N_IN < 1 || N_IN > 4) begin : g_bad_param
    $error("gate_truth_sequencer: need SETTLE >= 1 and 1 <= N_IN <= 4");
  end

  state_t        state;
  state_t        state_next;
  logic          tmr_load;
  logic          tmr_dec;
  logic          tmr_zero;
  logic          take_start;
  logic          do_sample;
  logic          mismatch;
  logic          last_vec;
  logic [CW-1:0] err_next;

  settle_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (RELOAD),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  // Case inequality so an X or Z from the gate is reported as a failure.
  assign mismatch  = (dut_out !== TRUTH[in_vec]);
  assign last_vec  = (in_vec == LAST_VEC);
  assign err_next  = err_count + CW'(mismatch);
  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    tmr_load   = 1'b0;
    tmr_dec    = 1'b0;
    take_start = 1'b0;
    do_sample  = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          take_start = 1'b1;
          tmr_load   = 1'b1;
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (tmr_zero) begin
          state_next = ST_SAMPLE;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_SAMPLE: begin
        do_sample = 1'b1;
        if (last_vec) begin
          state_next = ST_DONE;
        end else begin
          tmr_load   = 1'b1;
          state_next = ST_WAIT;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      in_vec     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_vec   <= '0;
      fail_valid <= 1'b0;
    end else if (take_start) begin
      in_vec     <= '0;
      busy       <= 1'b1;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_vec   <= '0;
      fail_valid <= 1'b0;
    end else if (do_sample) begin
      if (mismatch) begin
        err_count <= err_next;
        if (!fail_valid) begin
          fail_vec   <= in_vec;
          fail_valid <= 1'b1;
        end
      end
      // pass must account for the vector sampled on this same edge.
      if (last_vec) begin
        busy <= 1'b0;
        done <= 1'b1;
        pass <= (err_next == '0);
      end else begin
        in_vec <= in_vec + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_gate_truth_sequencer.sv
// Bench for gate_truth_sequencer: a behavioural gate driven from a response
// table, directed and random sweeps, and a truth-table reference model.
module tb_gate_truth_sequencer;
  import gate_test_pkg::*;

  localparam int         NV    = 4;
  localparam int         ST    = 1;
  localparam int         CYC   = NV * (ST + 1);
  localparam logic [3:0] EXP_T = 4'b1110;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] in_vec;
  logic       dut_out;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] err_count;
  logic [1:0] fail_vec;
  logic       fail_valid;
  state_t     fsm_state;

  logic       resp [NV];
  logic [1:0] exp_q[$];
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  // Behavioural gate under test: its output for each vector comes from resp.
  assign dut_out = resp[in_vec];

  gate_truth_sequencer #(.N_IN(2), .SETTLE(ST), .TRUTH(TT_OR)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_vec     (in_vec),
    .dut_out    (dut_out),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .err_count  (err_count),
    .fail_vec   (fail_vec),
    .fail_valid (fail_valid),
    .fsm_state  (fsm_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_gate(input logic r0, input logic r1, input logic r2, input logic r3);
    resp[0] = r0;
    resp[1] = r1;
    resp[2] = r2;
    resp[3] = r3;
  endtask

  // Reference: every vector whose response differs from the table is an
  // error; the lowest such vector is the one reported.
  task automatic model(output int e, output int fv, output bit fvalid);
    e = 0;
    fv = 0;
    fvalid = 0;
    for (int v = 0; v < NV; v++) begin
      if (resp[v] !== EXP_T[v]) begin
        e++;
        if (!fvalid) begin
          fv = v;
          fvalid = 1;
        end
      end
    end
  endtask

  task automatic run_sweep(input string tag, input bit hold);
    int e;
    int fv;
    bit fvalid;
    model(e, fv, fvalid);
    exp_q.delete();
    for (int k = 0; k < CYC; k++) exp_q.push_back(2'(k / (ST + 1)));
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int k = 0; k < CYC; k++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      check({tag, ".in_vec"}, in_vec, exp_q.pop_front());
      check({tag, ".busy"}, busy, 1);
      check({tag, ".done"}, done, 0);
      check({tag, ".pass_low"}, pass, 0);
    end
    @(negedge clk);
    check({tag, ".done_end"}, done, 1);
    check({tag, ".busy_end"}, busy, 0);
    check({tag, ".pass"}, pass, (e == 0));
    check({tag, ".err_count"}, err_count, e);
    check({tag, ".fail_valid"}, fail_valid, fvalid);
    check({tag, ".fail_vec"}, fail_vec, fvalid ? fv : 0);
    check({tag, ".in_vec_last"}, in_vec, NV - 1);
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    set_gate(1'b0, 1'b1, 1'b1, 1'b1);

    // Reset state
    repeat (3) @(negedge clk);
    check("rst.in_vec", in_vec, 0);
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.pass", pass, 0);
    check("rst.err_count", err_count, 0);
    check("rst.fail_valid", fail_valid, 0);
    check("rst.state", fsm_state, ST_IDLE);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("idle.busy", busy, 0);

    // Correct OR gate
    run_sweep("or_ok", 1'b0);

    // Output stuck at 0
    set_gate(1'b0, 1'b0, 1'b0, 1'b0);
    run_sweep("stuck0", 1'b0);

    // AND gate checked against the OR table
    set_gate(1'b0, 1'b0, 1'b0, 1'b1);
    run_sweep("and_gate", 1'b0);

    // Reset during the settle wait of vector 10
    set_gate(1'b0, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("midrst.in_vec_pre", in_vec, 2);
    rst = 1'b0;
    @(negedge clk);
    check("midrst.in_vec", in_vec, 0);
    check("midrst.busy", busy, 0);
    check("midrst.done", done, 0);
    check("midrst.err_count", err_count, 0);
    check("midrst.fail_valid", fail_valid, 0);
    check("midrst.state", fsm_state, ST_IDLE);
    rst = 1'b1;
    run_sweep("after_rst", 1'b0);

    // start held high: ignored while busy, restarts once DONE
    run_sweep("hold", 1'b1);
    @(negedge clk);
    check("restart.done", done, 0);
    check("restart.busy", busy, 1);
    check("restart.in_vec", in_vec, 0);
    check("restart.err_count", err_count, 0);
    start = 1'b0;
    repeat (CYC) @(negedge clk);
    check("restart.done_end", done, 1);
    check("restart.pass", pass, 1);

    // X on the gate output at vector 11 only
    set_gate(1'b0, 1'b1, 1'b1, 1'bx);
    run_sweep("x_out", 1'b0);

    // Random gate responses, occasionally unknown
    for (int n = 0; n < 12; n++) begin
      for (int v = 0; v < NV; v++) begin
        resp[v] = ($urandom_range(0, 9) == 0) ? 1'bx : 1'($urandom_range(0, 1));
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_sweep($sformatf("rand%0d", n), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gate_truth_sequencer.md
Name: gate_truth_sequencer

Overview:
Sequential stimulus-and-check stage for the switch-level gate library. It sits directly upstream of a gate under test (e.g. the CMOS OR cell) and consumes that gate's output. It drives every input vector in ascending order, waits a programmable settle time, and samples the gate output. It compares each sample against a parameterised truth table and reports the mismatch count, the first failing vector, and pass/done status.

Parameters:
N_IN, 2, number of gate inputs driven (1..4)
SETTLE, 1, cycles each vector is held before sampling (>=1; 0 is an elaboration error)
TRUTH, 4'b1110, expected output per vector, indexed by vector value (width 2**N_IN; default = OR)

Ports:
clk  input  1  single clock, all logic on rising edge
rst  input  1  synchronous reset, active-low
start  input  1  one-cycle request to begin a full sweep
in_vec  output  N_IN  stimulus to the gate under test; bit 0 = in_1, bit 1 = in_2
dut_out  input  1  gate-under-test output
busy  output  1  high while a sweep is in progress
done  output  1  high from sweep completion until the next accepted start or reset
pass  output  1  high with done when err_count == 0
err_count  output  N_IN+1  number of mismatching vectors in the last or current sweep
fail_vec  output  N_IN  first mismatching vector
fail_valid  output  1  fail_vec holds a captured value

Behaviour:
- Reset: rst low at a rising edge sets all outputs to 0: in_vec, busy, done, pass, err_count, fail_vec, fail_valid. The FSM goes to IDLE and the settle counter clears. Reset applies mid-sweep with no partial reporting.
- FSM states: IDLE, WAIT, SAMPLE, DONE.
- IDLE: waits for start=1. On start: in_vec<=0, busy<=1, err_count<=0, fail_valid<=0, fail_vec<=0, settle counter<=SETTLE-1, then go to WAIT.
- WAIT: holds in_vec. Decrements the counter each cycle. Goes to SAMPLE on the cycle the counter is 0, so in_vec is stable for SETTLE cycles before the sample.
- SAMPLE, 1 cycle: mismatch = (dut_out !== TRUTH[in_vec]). An X or Z on dut_out counts as a mismatch.
- SAMPLE, on mismatch: err_count++. If fail_valid=0, capture fail_vec<=in_vec and set fail_valid<=1.
- SAMPLE, exit: if in_vec == 2**N_IN-1, go to DONE with busy<=0, done<=1, and pass<=(final err_count==0), where the final count includes this sample. Otherwise in_vec<=in_vec+1, reload the counter, and go to WAIT.
- Latency: each vector occupies SETTLE+1 cycles. done rises 2**N_IN*(SETTLE+1) cycles after the start-accept edge.
- DONE: holds all results and leaves in_vec at the last vector. A start here is accepted exactly as in IDLE (restart), which clears done, pass and the results.
- start while busy (WAIT/SAMPLE) is ignored.
- Width rule: err_count cannot overflow, since the maximum 2**N_IN fits in N_IN+1 bits. in_vec is never incremented past all-ones.
- pass is only meaningful when done=1 and is 0 otherwise.

Decomposition:
- Shared package gate_test_pkg:
  - FSM state enum.
  - Named truth constants for 2-input gates: TT_OR=4'b1110, TT_AND=4'b1000, TT_NOR=4'b0001, TT_NAND=4'b0111, TT_XOR=4'b0110.
  - Helper function for the count width N_IN+1.
- One natural sub-module: settle_timer, a loadable down-counter with a zero flag. It is reused by later sweep/checker stages.

Test Plan:
1. N_IN=2, SETTLE=1, TRUTH=TT_OR, behavioural OR as the gate; pulse start -> in_vec steps 00,01,10,11, each held 2 cycles; done=1 and pass=1 at the 8th edge after the start-accept edge; err_count=0, fail_valid=0.
2. dut_out stuck at 0 -> err_count=3, fail_vec=01, fail_valid=1, pass=0, done=1.
3. Gate replaced by AND, expected TT_OR -> err_count=2, fail_vec=01; vector 10 also counted but not captured.
4. rst driven low during WAIT of vector 10 -> at the next edge all outputs are 0 and the FSM is in IDLE; release rst and pulse start -> a full clean sweep gives pass=1.
5. start held high for the whole sweep -> no restart until DONE; in DONE the still-high start restarts the sweep (done clears, in_vec=00, err_count=0).
6. dut_out forced to X at vector 11 only -> err_count=1, fail_vec=11, pass=0.
